// File: rtl/afifo_rd_packer.sv
// Read-side packer for the async FIFO: pops DATA_W words and groups PACK_N of them
// into one wide beat on a valid/ready output; flush emits a partial beat.
module afifo_rd_packer #(
  parameter int DATA_W = 8,
  parameter int PACK_N = 4,
  parameter int CNT_W  = $clog2(PACK_N + 1)
) (
  input  logic                     rdclk,
  input  logic                     arst_n,
  input  logic                     empty,
  output logic                     pop,
  input  logic [DATA_W-1:0]        rd_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W*PACK_N-1:0] out_data,
  output logic [CNT_W-1:0]         out_cnt,
  output logic                     busy
);
  // Output handshake: a beat transfers on a rising edge where out_valid & out_ready;
  // while out_valid & !out_ready, out_data/out_cnt hold and out_valid stays high.

  localparam int               BEAT_W = DATA_W * PACK_N;
  localparam logic [CNT_W-1:0] FULL   = CNT_W'(PACK_N);

  logic [BEAT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic              flush_pend_q, flush_pend_d;
  logic              out_valid_q, out_valid_d;
  logic [BEAT_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;

  logic [CNT_W:0]    in_flight;
  logic [CNT_W-1:0]  cnt_cap;
  logic [BEAT_W-1:0] acc_cap;
  logic [BEAT_W-1:0] acc_masked;
  logic              slot_free;
  logic              full_now;
  logic              flush_exec;
  logic              xfer;

  always_comb begin
    in_flight = {1'b0, cnt_q} + {{CNT_W{1'b0}}, pend_q};
    pop       = arst_n & ~empty & ~flush_pend_q & (in_flight < {1'b0, FULL});

    // acc_cap is the accumulator after the in-flight word (if any) lands
    cnt_cap    = cnt_q + CNT_W'(pend_q);
    acc_cap    = acc_q;
    acc_masked = '0;
    for (int i = 0; i < PACK_N; i++) begin
      if (pend_q && (cnt_q == CNT_W'(i))) begin
        acc_cap[i*DATA_W +: DATA_W] = rd_data;
      end
      if (CNT_W'(i) < cnt_cap) begin
        acc_masked[i*DATA_W +: DATA_W] = acc_cap[i*DATA_W +: DATA_W];
      end
    end

    slot_free  = ~out_valid_q | out_ready;
    full_now   = (cnt_cap == FULL);
    // a flush waits for any in-flight word so that word lands in the flushed beat
    flush_exec = (flush_pend_q | flush) & ~pend_q & (cnt_q != '0);
    xfer       = slot_free & (full_now | flush_exec);

    acc_d       = xfer ? '0 : acc_cap;
    cnt_d       = xfer ? '0 : cnt_cap;
    pend_d      = pop;
    out_valid_d = xfer | (out_valid_q & ~out_ready);
    out_data_d  = xfer ? acc_masked : out_data_q;
    out_cnt_d   = xfer ? cnt_cap : out_cnt_q;

    if (xfer) begin
      flush_pend_d = 1'b0;
    end else if (flush && ((cnt_q != '0) || pend_q)) begin
      flush_pend_d = 1'b1;
    end else begin
      flush_pend_d = flush_pend_q;
    end
  end

  always_ff @(posedge rdclk or negedge arst_n) begin
    if (!arst_n) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      flush_pend_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_cnt_q    <= '0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      flush_pend_q <= flush_pend_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_cnt_q    <= out_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_cnt   = out_cnt_q;
  assign busy      = (cnt_q != '0) | pend_q | flush_pend_q | out_valid_q;

endmodule

// File: tb/tb_afifo_rd_packer.sv
// Bench for afifo_rd_packer: FIFO model with registered read, expected-beat queue,
// table of single-beat vectors plus hand-written stall/flush/reset sequences.
module tb_afifo_rd_packer;
  localparam int DATA_W = 8;
  localparam int PACK_N = 4;
  localparam int CNT_W  = 3;
  localparam int BEAT_W = 32;
  localparam int EXP_W  = CNT_W + BEAT_W;

  logic              rdclk = 1'b0;
  logic              arst_n = 1'b0;
  logic              empty = 1'b1;
  logic              pop;
  logic [DATA_W-1:0] rd_data = '0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [BEAT_W-1:0] out_data;
  logic [CNT_W-1:0]  out_cnt;
  logic              busy;

  // ---------------- clock / reset ----------------
  always #5 rdclk = ~rdclk;

  afifo_rd_packer #(.DATA_W(DATA_W), .PACK_N(PACK_N)) dut (
    .rdclk    (rdclk),
    .arst_n   (arst_n),
    .empty    (empty),
    .pop      (pop),
    .rd_data  (rd_data),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_cnt  (out_cnt),
    .busy     (busy)
  );

  // ---------------- scoreboard state ----------------
  logic [DATA_W-1:0] fifo_q[$];
  logic [EXP_W-1:0]  exp_q[$];
  int                pop_cyc[$];
  int                checks = 0;
  int                failures = 0;
  int                cyc = 0;
  logic              hold_chk = 1'b0;
  logic [BEAT_W-1:0] held_data = '0;
  logic [CNT_W-1:0]  held_cnt = '0;

  typedef struct {
    int                n;
    logic [BEAT_W-1:0] words;
    logic              fl;
    logic [BEAT_W-1:0] exp_data;
    logic [CNT_W-1:0]  exp_cnt;
  } vec_t;

  vec_t vec[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_word(input logic [DATA_W-1:0] w);
    fifo_q.push_back(w);
    empty = 1'b0;
  endtask

  task automatic push_exp(input logic [BEAT_W-1:0] d, input logic [CNT_W-1:0] c);
    exp_q.push_back({c, d});
  endtask

  // One clock: sample at negedge, then update the FIFO read port just after posedge.
  task automatic cycle();
    logic              pop_s;
    logic [DATA_W-1:0] w;
    logic [EXP_W-1:0]  e;
    w = '0;
    @(negedge rdclk);
    pop_s = pop;
    if (pop_s) begin
      pop_cyc.push_back(cyc);
      if (fifo_q.size() == 0) begin
        check("pop_while_empty", 64'(pop_s), 64'd0);
      end else begin
        w = fifo_q.pop_front();
      end
    end
    if (hold_chk) begin
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_data", 64'(out_data), 64'(held_data));
      check("hold_cnt", 64'(out_cnt), 64'(held_cnt));
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat actual=0x%0h/%0d required=none", out_data, out_cnt);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", 64'(out_data), 64'(e[BEAT_W-1:0]));
        check("beat_cnt", 64'(out_cnt), 64'(e[EXP_W-1:BEAT_W]));
      end
    end
    hold_chk  = out_valid && !out_ready;
    held_data = out_data;
    held_cnt  = out_cnt;
    @(posedge rdclk);
    #1;
    rd_data = pop_s ? w : DATA_W'($urandom);
    empty   = (fifo_q.size() == 0);
    cyc++;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while (k < budget && !(exp_q.size() == 0 && fifo_q.size() == 0 && !busy)) begin
      cycle();
      k++;
    end
    check(name, 64'(exp_q.size() == 0 && fifo_q.size() == 0 && !busy), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    logic [BEAT_W-1:0] beat;
    int                n0;

    vec[0] = '{n: 4, words: 32'h44332211, fl: 1'b0, exp_data: 32'h44332211, exp_cnt: 3'd4};
    vec[1] = '{n: 2, words: 32'h0000BBAA, fl: 1'b1, exp_data: 32'h0000BBAA, exp_cnt: 3'd2};
    vec[2] = '{n: 1, words: 32'h0000005A, fl: 1'b1, exp_data: 32'h0000005A, exp_cnt: 3'd1};
    vec[3] = '{n: 3, words: 32'h00302010, fl: 1'b1, exp_data: 32'h00302010, exp_cnt: 3'd3};
    vec[4] = '{n: 4, words: 32'hDEADBEEF, fl: 1'b0, exp_data: 32'hDEADBEEF, exp_cnt: 3'd4};
    vec[5] = '{n: 4, words: 32'h0102FF80, fl: 1'b1, exp_data: 32'h0102FF80, exp_cnt: 3'd4};
    for (int r = 6; r < 8; r++) begin
      beat   = $urandom;
      vec[r] = '{n: 4, words: beat, fl: 1'b0, exp_data: beat, exp_cnt: 3'd4};
    end

    // reset values
    #1;
    check("rst_pop", 64'(pop), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_cnt", 64'(out_cnt), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    repeat (3) cycle();
    arst_n = 1'b1;
    repeat (2) cycle();

    // table of single beats, full and flushed
    for (int r = 0; r < 8; r++) begin
      pop_cyc.delete();
      for (int i = 0; i < vec[r].n; i++) push_word(vec[r].words[8*i +: 8]);
      push_exp(vec[r].exp_data, vec[r].exp_cnt);
      if (vec[r].fl) begin
        repeat (vec[r].n + 3) cycle();
        if (vec[r].n < PACK_N) check("early_beat", 64'(out_valid), 64'd0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
      end
      wait_idle("row_idle", 40);
      check("row_pops", 64'(pop_cyc.size()), 64'(vec[r].n));
      if (pop_cyc.size() == vec[r].n)
        check("row_pop_span", 64'(pop_cyc[vec[r].n-1] - pop_cyc[0]), 64'(vec[r].n - 1));
    end

    // back-to-back beats: one pop bubble per beat
    pop_cyc.delete();
    for (int i = 1; i <= 8; i++) push_word(8'(i));
    push_exp(32'h04030201, 3'd4);
    push_exp(32'h08070605, 3'd4);
    wait_idle("b2b_idle", 40);
    check("b2b_pops", 64'(pop_cyc.size()), 64'd8);
    if (pop_cyc.size() == 8) begin
      check("b2b_span", 64'(pop_cyc[7] - pop_cyc[0]), 64'd8);
      check("b2b_bubble", 64'(pop_cyc[4] - pop_cyc[3]), 64'd2);
    end

    // downstream stalled: one beat held, one accumulated, pop stops
    pop_cyc.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) push_word(8'(8'h31 + i));
    push_exp(32'h34333231, 3'd4);
    push_exp(32'h38373635, 3'd4);
    push_exp(32'h3C3B3A39, 3'd4);
    repeat (25) cycle();
    check("stall_pops", 64'(pop_cyc.size()), 64'd8);
    check("stall_pop_low", 64'(pop), 64'd0);
    check("stall_valid", 64'(out_valid), 64'd1);
    check("stall_data", 64'(out_data), 64'h34333231);
    out_ready = 1'b1;
    wait_idle("stall_idle", 60);
    check("stall_total_pops", 64'(pop_cyc.size()), 64'd12);

    // flush while the output slot is busy; second flush ignored; pop held low
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'(8'h41 + i));
    push_exp(32'h44434241, 3'd4);
    repeat (6) cycle();
    push_word(8'hAA);
    push_word(8'hBB);
    push_exp(32'h0000BBAA, 3'd2);
    repeat (5) cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    n0 = pop_cyc.size();
    for (int i = 0; i < 4; i++) push_word(8'(8'h51 + i));
    push_exp(32'h54535251, 3'd4);
    for (int k = 0; k < 4; k++) begin
      flush = (k == 1);
      cycle();
    end
    flush = 1'b0;
    check("fwait_no_pop", 64'(pop_cyc.size()), 64'(n0));
    check("fwait_busy", 64'(busy), 64'd1);
    out_ready = 1'b1;
    wait_idle("fwait_idle", 40);

    // flush while a word is in flight
    push_word(8'hAA);
    repeat (3) cycle();
    push_word(8'hCC);
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    push_exp(32'h0000CCAA, 3'd2);
    push_word(8'hDD);
    #1;
    check("fpend_pop_low", 64'(pop), 64'd0);
    push_word(8'hEE);
    push_word(8'hFF);
    push_word(8'h11);
    push_exp(32'h11FFEEDD, 3'd4);
    wait_idle("fpend_idle", 40);

    // random words with random backpressure
    for (int b = 0; b < 10; b++) begin
      beat = $urandom;
      for (int i = 0; i < 4; i++) push_word(beat[8*i +: 8]);
      push_exp(beat, 3'd4);
    end
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) begin
      out_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    out_ready = 1'b1;
    wait_idle("rand_idle", 40);

    // asynchronous reset with cnt=3 and a held beat
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'(8'h61 + i));
    push_exp(32'h64636261, 3'd4);
    repeat (6) cycle();
    for (int i = 0; i < 3; i++) push_word(8'(8'h71 + i));
    repeat (6) cycle();
    check("prerst_valid", 64'(out_valid), 64'd1);
    push_word(8'h91);
    push_word(8'h92);
    arst_n = 1'b0;
    #1;
    check("arst_pop", 64'(pop), 64'd0);
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_cnt", 64'(out_cnt), 64'd0);
    check("arst_data", 64'(out_data), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    fifo_q.delete();
    exp_q.delete();
    empty    = 1'b1;
    hold_chk = 1'b0;
    repeat (2) cycle();
    arst_n    = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_word(8'(8'h81 + i));
    repeat (10) cycle();
    check("postrst_no_beat", 64'(out_valid), 64'd0);
    check("postrst_busy", 64'(busy), 64'd1);
    push_word(8'h84);
    push_exp(32'h84838281, 3'd4);
    wait_idle("postrst_idle", 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
